// File: rtl/jpeg_izigzag_block_assembler_if.sv
// Coefficient-in / block-out bus for jpeg_izigzag_block_assembler.
//   coef_in/coef_valid/coef_sof/coef_ready : zigzag coefficient stream (valid/ready)
//   block_y/block_cb/block_cr              : raster-ordered blocks, index i at [i*DATA_WIDTH +: DATA_WIDTH]
//   block_valid/block_ready                : block handoff handshake
//   sync_err                               : sticky framing-error flag
// master = producer/consumer side, slave = assembler side.
interface jpeg_izigzag_block_assembler_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_COUNT = 64
);
  logic [DATA_WIDTH-1:0]             coef_in;
  logic                              coef_valid;
  logic                              coef_sof;
  logic                              coef_ready;
  logic [DATA_WIDTH*PIXEL_COUNT-1:0] block_y;
  logic [DATA_WIDTH*PIXEL_COUNT-1:0] block_cb;
  logic [DATA_WIDTH*PIXEL_COUNT-1:0] block_cr;
  logic                              block_valid;
  logic                              block_ready;
  logic                              sync_err;

  modport master (
    output coef_in, coef_valid, coef_sof, block_ready,
    input  coef_ready, block_y, block_cb, block_cr, block_valid, sync_err
  );

  modport slave (
    input  coef_in, coef_valid, coef_sof, block_ready,
    output coef_ready, block_y, block_cb, block_cr, block_valid, sync_err
  );
endinterface

// File: rtl/jpeg_izigzag_block_assembler.sv
// Inverse-zigzag block assembler: collects 64 Y, 64 Cb, 64 Cr zigzag-ordered
// coefficients, writes each into its raster slot and presents the three blocks
// together until the consumer takes them.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : jpeg_izigzag_block_assembler_if.slave (coefficient stream, block handoff, sync_err)
// Optional feature: define JPEG_IZZ_RESYNC_EN to resynchronise on coef_sof and
// flag framing errors on sync_err; otherwise coef_sof is ignored and sync_err is 0.
module jpeg_izigzag_block_assembler #(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_DEPTH  = 8,
  parameter int PIXEL_COUNT = DATA_DEPTH*DATA_DEPTH
)(
  input logic                            clk,
  input logic                            reset_n,
  jpeg_izigzag_block_assembler_if.slave  bus
);
  localparam int KW = $clog2(PIXEL_COUNT);

  typedef enum logic [1:0] {LOAD_Y, LOAD_CB, LOAD_CR, HOLD} state_t;

  // Zigzag position that lands on raster index r: walk the anti-diagonals,
  // even ones bottom-left to top-right, odd ones the other way.
  function automatic int zz_inv(input int r);
    int idx, row, rmin, rmax, res;
    idx = 0;
    res = 0;
    for (int s = 0; s < 2*DATA_DEPTH-1; s++) begin
      rmax = (s < DATA_DEPTH) ? s : DATA_DEPTH-1;
      rmin = (s < DATA_DEPTH) ? 0 : s-DATA_DEPTH+1;
      for (int t = 0; t < DATA_DEPTH; t++) begin
        if (t <= rmax-rmin) begin
          row = (s % 2 == 0) ? rmax-t : rmin+t;
          if (row*DATA_DEPTH + (s-row) == r) res = idx;
          idx++;
        end
      end
    end
    return res;
  endfunction

  state_t        state;
  logic [KW-1:0] k;
  logic          ready_q, valid_q, err_q;

  logic          xfer, at_sof, last, resync;
  logic          wr_y, wr_cb, wr_cr;
  logic [KW-1:0] wr_k;

  assign xfer   = bus.coef_valid & ready_q;
  assign at_sof = (state == LOAD_Y) && (k == '0);
  assign last   = (k == KW'(PIXEL_COUNT-1));

`ifdef JPEG_IZZ_RESYNC_EN
  // sof seen anywhere but the expected slot restarts the block at Y position 0
  assign resync = xfer & bus.coef_sof & ~at_sof;
`else
  assign resync = 1'b0;
`endif

  // A resync transfer is written as Y position 0 regardless of current state
  assign wr_k  = resync ? '0 : k;
  assign wr_y  = xfer & (resync | (state == LOAD_Y));
  assign wr_cb = xfer & ~resync & (state == LOAD_CB);
  assign wr_cr = xfer & ~resync & (state == LOAD_CR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= LOAD_Y;
      k       <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (resync) begin
      state <= LOAD_Y;
      k     <= KW'(1);
      err_q <= 1'b1;
    end else if (xfer) begin
`ifdef JPEG_IZZ_RESYNC_EN
      if (at_sof && !bus.coef_sof) err_q <= 1'b1;
`endif
      if (last) begin
        k <= '0;
        case (state)
          LOAD_Y:  state <= LOAD_CB;
          LOAD_CB: state <= LOAD_CR;
          default: begin
            // only LOAD_CR can get here: xfer needs ready, which HOLD drops
            state   <= HOLD;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
          end
        endcase
      end else begin
        k <= k + 1'b1;
      end
    end else if (valid_q && bus.block_ready) begin
      state   <= LOAD_Y;
      k       <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end
  end

  assign bus.coef_ready  = ready_q;
  assign bus.block_valid = valid_q;
  assign bus.sync_err    = err_q;

  // One storage lane per raster slot; each lane knows its own zigzag index,
  // so writes are a compare per lane instead of a wide demux.
  for (genvar r = 0; r < PIXEL_COUNT; r++) begin : g_lane
    localparam logic [KW-1:0] ZK = KW'(zz_inv(r));
    logic [DATA_WIDTH-1:0] y_r, cb_r, cr_r;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        y_r  <= '0;
        cb_r <= '0;
        cr_r <= '0;
      end else begin
        if (wr_y  && wr_k == ZK) y_r  <= bus.coef_in;
        if (wr_cb && wr_k == ZK) cb_r <= bus.coef_in;
        if (wr_cr && wr_k == ZK) cr_r <= bus.coef_in;
      end
    end

    assign bus.block_y [r*DATA_WIDTH +: DATA_WIDTH] = y_r;
    assign bus.block_cb[r*DATA_WIDTH +: DATA_WIDTH] = cb_r;
    assign bus.block_cr[r*DATA_WIDTH +: DATA_WIDTH] = cr_r;
  end
endmodule

// File: tb/tb_jpeg_izigzag_block_assembler.sv
module tb_jpeg_izigzag_block_assembler;
  localparam int W = 32;
  localparam int P = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  jpeg_izigzag_block_assembler_if #(.DATA_WIDTH(W), .PIXEL_COUNT(P)) bus ();

  jpeg_izigzag_block_assembler #(.DATA_WIDTH(W), .DATA_DEPTH(8), .PIXEL_COUNT(P)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Standard JPEG zigzag: position k -> raster index
  int zz [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  logic [W-1:0] exp_y [64];
  logic [W-1:0] exp_cb[64];
  logic [W-1:0] exp_cr[64];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] val(input int n);
    if (n < 64)       return W'(n + 1);
    else if (n < 128) return W'(100 + n - 64);
    else              return W'(200 + n - 128);
  endfunction

  function automatic logic [W-1:0] y_at(input int i);
    return bus.block_y[i*W +: W];
  endfunction
  function automatic logic [W-1:0] cb_at(input int i);
    return bus.block_cb[i*W +: W];
  endfunction
  function automatic logic [W-1:0] cr_at(input int i);
    return bus.block_cr[i*W +: W];
  endfunction

  task automatic check_block(input string tag);
    for (int i = 0; i < 64; i++) begin
      chk({tag, "_y"},  y_at(i),  exp_y[i]);
      chk({tag, "_cb"}, cb_at(i), exp_cb[i]);
      chk({tag, "_cr"}, cr_at(i), exp_cr[i]);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the word.
  task automatic send(input logic [W-1:0] v, input bit sof, input int gap);
    int g;
    bus.coef_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.coef_in    = v;
    bus.coef_sof   = sof;
    bus.coef_valid = 1'b1;
    g = 0;
    while (!bus.coef_ready && g < 40) begin @(posedge clk); #1; g++; end
    if (!bus.coef_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.coef_valid = 1'b0;
    bus.coef_sof   = 1'b0;
  endtask

  task automatic send_range(input int n0, input int n1, input bit rnd);
    for (int n = n0; n <= n1; n++)
      send(val(n), n == 0, rnd ? int'($urandom_range(0, 1)) : 0);
  endtask

  task automatic release_block(input string tag);
    bus.block_ready = 1'b1;
    @(posedge clk); #1;
    bus.block_ready = 1'b0;
    chk({tag, "_rel_valid"}, W'(bus.block_valid), 32'd0);
    chk({tag, "_rel_ready"}, W'(bus.coef_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 64; k++) begin
      exp_y [zz[k]] = W'(k + 1);
      exp_cb[zz[k]] = W'(100 + k);
      exp_cr[zz[k]] = W'(200 + k);
    end
    bus.coef_in     = '0;
    bus.coef_valid  = 1'b0;
    bus.coef_sof    = 1'b0;
    bus.block_ready = 1'b0;

    // reset state
    #12;
    chk("rst_valid", W'(bus.block_valid), 32'd0);
    chk("rst_ready", W'(bus.coef_ready), 32'd1);
    chk("rst_err",   W'(bus.sync_err), 32'd0);
    chk("rst_y_or",  W'(|bus.block_y), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // back-to-back block
    send_range(0, 190, 1'b0);
    chk("a_pre_valid", W'(bus.block_valid), 32'd0);
    send(val(191), 1'b0, 0);
    chk("a_valid", W'(bus.block_valid), 32'd1);
    chk("a_ready", W'(bus.coef_ready), 32'd0);
    chk("a_y8",   y_at(8),   32'd3);
    chk("a_y16",  y_at(16),  32'd4);
    chk("a_y63",  y_at(63),  32'd64);
    chk("a_cb1",  cb_at(1),  32'd101);
    chk("a_cr0",  cr_at(0),  32'd200);
    check_block("a");

    // stall in HOLD with a pending coefficient
    bus.coef_in    = 32'hdeadbeef;
    bus.coef_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("b_ready", W'(bus.coef_ready), 32'd0);
      chk("b_valid", W'(bus.block_valid), 32'd1);
      chk("b_y0",    y_at(0), 32'd1);
    end
    check_block("b");
    release_block("b");
    bus.coef_valid = 1'b0;

    // random 50% gaps
    send_range(0, 191, 1'b1);
    chk("c_valid", W'(bus.block_valid), 32'd1);
    check_block("c");
    release_block("c");

    // async reset mid-block
    send_range(0, 69, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    chk("d_valid", W'(bus.block_valid), 32'd0);
    chk("d_ready", W'(bus.coef_ready), 32'd1);
    chk("d_y1",    y_at(1), 32'd0);
    chk("d_cb0",   cb_at(0), 32'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    send_range(0, 191, 1'b0);
    chk("d2_valid", W'(bus.block_valid), 32'd1);
    check_block("d2");
    release_block("d2");

    // sof in the middle of a block
    send_range(0, 29, 1'b0);
    send(val(0), 1'b1, 0);
`ifdef JPEG_IZZ_RESYNC_EN
    chk("e_err", W'(bus.sync_err), 32'd1);
    send_range(1, 190, 1'b0);
    chk("e_pre_valid", W'(bus.block_valid), 32'd0);
    send(val(191), 1'b0, 0);
    chk("e_valid", W'(bus.block_valid), 32'd1);
    check_block("e");
`else
    chk("e_err", W'(bus.sync_err), 32'd0);
    send_range(1, 160, 1'b0);
    chk("e_pre_valid", W'(bus.block_valid), 32'd0);
    send(val(161), 1'b0, 0);
    chk("e_valid", W'(bus.block_valid), 32'd1);
    chk("e_err2",  W'(bus.sync_err), 32'd0);
    chk("e_y0",    y_at(0), 32'd1);
    chk("e_y21",   y_at(21), 32'd1);
    chk("e_y14",   y_at(14), 32'd30);
`endif
    release_block("e");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/jpeg_izigzag_block_assembler.md
JPEG_IZIGZAG_BLOCK_ASSEMBLER -- requirements
Module: jpeg_izigzag_block_assembler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one coefficient.
REQ-002 SHALL have parameter DATA_DEPTH, default 8, block edge length.
REQ-003 SHALL have parameter PIXEL_COUNT, default DATA_DEPTH*DATA_DEPTH (64), coefficients per channel block.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port coef_in  input  DATA_WIDTH  one zigzag-ordered coefficient.
REQ-007 SHALL have port coef_valid  input  1  coef_in is valid.
REQ-008 SHALL have port coef_sof  input  1  marks Y coefficient 0 of a block; qualified by coef_valid.
REQ-009 SHALL have port coef_ready  output  1  block accepts a coefficient this cycle.
REQ-010 SHALL have port block_y  output  DATA_WIDTH*PIXEL_COUNT  raster-order Y block; raster index i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port block_cb  output  DATA_WIDTH*PIXEL_COUNT  raster-order Cb block, same packing.
REQ-012 SHALL have port block_cr  output  DATA_WIDTH*PIXEL_COUNT  raster-order Cr block, same packing.
REQ-013 SHALL have port block_valid  output  1  all three blocks complete and stable.
REQ-014 SHALL have port block_ready  input  1  downstream consumes the block.
REQ-015 SHALL have port sync_err  output  1  sticky framing-error flag.

Function
REQ-016 SHALL accept a coefficient only on a cycle with coef_valid=1 and coef_ready=1 (transfer).
REQ-017 SHALL receive per block 3*PIXEL_COUNT coefficients in fixed order: 64 Y, 64 Cb, 64 Cr, each in standard JPEG zigzag order.
REQ-018 SHALL write the zigzag-position-k coefficient to raster index ZZ(k) of the current channel, ZZ being the standard JPEG table (k=0..6 -> 0,1,8,16,9,2,3; k=63 -> 63).
REQ-019 SHALL use states LOAD_Y, LOAD_CB, LOAD_CR, HOLD; 6-bit position counter k.
REQ-020 SHALL increment k on each transfer; at k=63, wrap k to 0 and advance LOAD_Y->LOAD_CB->LOAD_CR->HOLD.
REQ-021 SHALL drive coef_ready=1 in LOAD_* states and 0 in HOLD.
REQ-022 SHALL drive block_valid=1 exactly in HOLD, first asserted the cycle after the 192nd transfer.
REQ-023 SHALL keep block_y/cb/cr stable while block_valid=1.
REQ-024 SHALL, on block_valid=1 and block_ready=1, go to LOAD_Y with k=0; no coefficient accepted that cycle; earliest next transfer is the following cycle.
REQ-025 SHALL keep block_valid high with unchanged data while block_ready=0 (no timeout).
REQ-026 SHALL overwrite, not clear, block registers when the next block loads; raster positions are all rewritten before block_valid reasserts.
REQ-027 SHALL pass coefficient bits unchanged (no sign extension, saturation or arithmetic).

Reset
REQ-028 SHALL on reset_n=0 immediately set state LOAD_Y, k=0, block_y/cb/cr all zero, block_valid=0, sync_err=0.
REQ-029 SHALL drive coef_ready=1 after reset release; reset mid-block or in HOLD discards the partial/held block.

Configuration
REQ-030 SHALL, with macro JPEG_IZZ_RESYNC_EN defined, on a transfer with coef_sof=1 while not at (LOAD_Y, k=0): set sync_err=1, store the coefficient as Y raster 0, set state LOAD_Y, k=1.
REQ-031 SHALL, with JPEG_IZZ_RESYNC_EN defined, also set sync_err on a transfer at (LOAD_Y, k=0) with coef_sof=0, storing normally; sync_err clears only on reset.
REQ-032 SHALL, without JPEG_IZZ_RESYNC_EN, ignore coef_sof and tie sync_err to 0.

Verification
REQ-033 SHALL cover: 192 back-to-back transfers, Y value k+1, Cb 100+k, Cr 200+k -> block_valid the cycle after transfer 192; block_y raster 8 = 3, raster 16 = 4, raster 63 = 64; block_cb raster 1 = 101; block_cr raster 0 = 200.
REQ-034 SHALL cover: block_ready=0 for 10 cycles in HOLD with coef_valid=1 -> coef_ready=0, outputs unchanged, block_valid held; block_ready=1 -> next cycle coef_ready=1, LOAD_Y.
REQ-035 SHALL cover: coef_valid toggled randomly 50% -> identical block contents to REQ-033 case.
REQ-036 SHALL cover: reset_n pulsed low after 70 transfers -> outputs zero asynchronously, then full fresh block assembles correctly.
REQ-037 SHALL cover (JPEG_IZZ_RESYNC_EN): coef_sof=1 at transfer 30 -> sync_err=1, counter restarts, next 191 transfers yield a correct block; without the macro sync_err stays 0 and block completes after 192 transfers.
